// File: rtl/btn_pkg.sv
// Shared helpers for the button conditioner: ms-to-cycle conversion and counter sizing.
package btn_pkg;

  localparam int unsigned DEF_CLK_HZ      = 100_000_000;
  localparam int unsigned DEF_DEBOUNCE_MS = 20;
  localparam int unsigned DEF_LONG_MS     = 1000;

  function automatic int unsigned cycles_from_ms(input int unsigned clk_hz, input int unsigned ms);
    return (clk_hz / 1000) * ms;
  endfunction

  // Width able to hold 0..cyc; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned cyc);
    return (cyc < 2) ? 1 : $clog2(cyc + 1);
  endfunction

  localparam int unsigned DEF_DB_CYC = cycles_from_ms(DEF_CLK_HZ, DEF_DEBOUNCE_MS);
  localparam int unsigned DEF_LP_CYC = cycles_from_ms(DEF_CLK_HZ, DEF_LONG_MS);

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop sync, debounce, edge pulses, toggle; long-press hold
// detector only when BTN_LONG_PRESS_EN is defined.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int unsigned DB_CYC = DEF_DB_CYC
`ifdef BTN_LONG_PRESS_EN
  ,
  parameter int unsigned LP_CYC = DEF_LP_CYC
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic tog_clr,
  output logic level,
  output logic rise,
  output logic fall,
  output logic tog,
  output logic long_press
);

  localparam int unsigned DB_W = cnt_width(DB_CYC);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYC - 1);

  logic            s0;
  logic            s1;
  logic [DB_W-1:0] db_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
    end else begin
      s0 <= btn;
      s1 <= s0;
    end
  end

  // Any sample agreeing with the current level restarts the qualification window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (s1 == level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt <= '0;
        level  <= s1;
        rise   <= s1;
        fall   <= ~s1;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tog <= 1'b0;
    end else if (tog_clr) begin
      tog <= 1'b0;
    end else if (rise) begin
      tog <= ~tog;
    end
  end

`ifdef BTN_LONG_PRESS_EN
  localparam int unsigned LP_W = cnt_width(LP_CYC);
  localparam logic [LP_W-1:0] LP_LAST = LP_W'(LP_CYC - 1);
  localparam logic [LP_W-1:0] LP_FIRE = LP_W'(LP_CYC - 2);

  logic [LP_W-1:0] lp_cnt;

  // Saturating at LP_LAST guarantees a single pulse per press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lp_cnt     <= '0;
      long_press <= 1'b0;
    end else if (!level) begin
      lp_cnt     <= '0;
      long_press <= 1'b0;
    end else if (lp_cnt != LP_LAST) begin
      lp_cnt     <= lp_cnt + LP_W'(1);
      long_press <= (lp_cnt == LP_FIRE);
    end else begin
      long_press <= 1'b0;
    end
  end
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Conditions N_BTN raw push-buttons into clean clk-domain level/pulse/toggle signals.
// Optional long-press pulse per channel is built only when BTN_LONG_PRESS_EN is defined.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned N_BTN       = 2,
  parameter int unsigned CLK_HZ      = DEF_CLK_HZ,
  parameter int unsigned DEBOUNCE_MS = DEF_DEBOUNCE_MS,
  parameter int unsigned LONG_MS     = DEF_LONG_MS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_i,
  input  logic [N_BTN-1:0] tog_clr,
  output logic [N_BTN-1:0] level_o,
  output logic [N_BTN-1:0] rise_o,
  output logic [N_BTN-1:0] fall_o,
  output logic [N_BTN-1:0] tog_o,
  output logic [N_BTN-1:0] long_o
);

  localparam int unsigned DB_CYC = cycles_from_ms(CLK_HZ, DEBOUNCE_MS);

  // Zero-length windows would make the counters meaningless; reject at elaboration.
  if (DB_CYC < 1 || cycles_from_ms(CLK_HZ, LONG_MS) < 2) begin : g_cfg_err
    $error("button_conditioner: debounce/long-press window too short");
  end

`ifdef BTN_LONG_PRESS_EN
  localparam int unsigned LP_CYC = cycles_from_ms(CLK_HZ, LONG_MS);
`endif

  for (genvar i = 0; i < int'(N_BTN); i++) begin : g_ch
    btn_debounce_ch #(
      .DB_CYC (DB_CYC)
`ifdef BTN_LONG_PRESS_EN
      ,
      .LP_CYC (LP_CYC)
`endif
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .btn        (btn_i[i]),
      .tog_clr    (tog_clr[i]),
      .level      (level_o[i]),
      .rise       (rise_o[i]),
      .fall       (fall_o[i]),
      .tog        (tog_o[i]),
      .long_press (long_o[i])
    );
  end

endmodule
